// File: rtl/isqrt_fsm_pkg.sv
// Shared types and parameter checks for the nested isqrt chain evaluator.
// The state enum is a 2-bit encoding; helpers size the index register and validate parameters.
package isqrt_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  function automatic bit params_ok(input int n_args, input int w);
    return (n_args >= 1) && (w >= 2) && ((w % 2) == 0);
  endfunction

  // Index register needs at least one bit even for a single-argument chain.
  function automatic int idx_width(input int n_args);
    return (n_args > 1) ? $clog2(n_args) : 1;
  endfunction

endpackage

// File: rtl/nested_isqrt_fsm.sv
// Sequential evaluator of res = isqrt(a0 + isqrt(a1 + ... isqrt(a[N_ARGS-1]))),
// time-sharing one external isqrt unit with a single request in flight.
module nested_isqrt_fsm
  import isqrt_fsm_pkg::*;
#(
  parameter int N_ARGS = 3,
  parameter int W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arg_vld,
  output logic              arg_rdy,
  input  logic [N_ARGS*W-1:0] args,
  output logic              res_vld,
  output logic [W-1:0]      res,
  output logic              isqrt_x_vld,
  output logic [W-1:0]      isqrt_x,
  input  logic              isqrt_y_vld,
  input  logic [W/2-1:0]    isqrt_y
);

  localparam int IW = idx_width(N_ARGS);
  localparam int HW = W / 2;

  if (!params_ok(N_ARGS, W)) begin : g_param_err
    $error("nested_isqrt_fsm: N_ARGS must be >= 1 and W even and >= 2");
  end

  state_e          state, state_nxt;
  logic [W-1:0]    arg_q [N_ARGS];
  logic [W-1:0]    acc_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_dec;
  logic [W-1:0]    res_q;
  logic            res_vld_q;
  logic            x_vld_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    x_nxt;
  logic [W-1:0]    y_ext;
  logic            capture;
  logic            take_y;
  logic            last;

  assign y_ext   = {{HW{1'b0}}, isqrt_y};
  assign idx_dec = idx_q - 1'b1;
  assign capture = (state == IDLE) && arg_vld;
  assign take_y  = (state == WAIT) && isqrt_y_vld;
  assign last    = (idx_q == '0);

  // Next state, plus the operand of the request that the next state will issue.
  always_comb begin
    state_nxt = state;
    x_nxt     = '0;
    unique case (state)
      IDLE: begin
        if (arg_vld) begin
          state_nxt = ISSUE;
          x_nxt     = args[W*(N_ARGS-1) +: W];
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (isqrt_y_vld) begin
          if (last) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = ISSUE;
            x_nxt     = arg_q[idx_dec] + y_ext;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers; request strobe and operand are registered so
  // they come straight from flops and are zero outside ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_q     <= '0;
      idx_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      x_vld_q   <= 1'b0;
      x_q       <= '0;
    end else begin
      state     <= state_nxt;
      x_vld_q   <= (state_nxt == ISSUE);
      x_q       <= x_nxt;
      res_vld_q <= 1'b0;
      if (capture) begin
        acc_q <= '0;
        idx_q <= IW'(N_ARGS - 1);
      end else if (take_y) begin
        acc_q <= y_ext;
        if (last) begin
          res_q     <= y_ext;
          res_vld_q <= 1'b1;
        end else begin
          idx_q <= idx_dec;
        end
      end
    end
  end

  // Argument bank is pure data: loaded on acceptance, never reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N_ARGS; i++) begin
        arg_q[i] <= args[W*i +: W];
      end
    end
  end

  assign arg_rdy     = (state == IDLE);
  assign res_vld     = res_vld_q;
  assign res         = res_q;
  assign isqrt_x_vld = x_vld_q;
  assign isqrt_x     = x_q;

endmodule

// File: tb/tb_nested_isqrt_fsm.sv
// Bench for nested_isqrt_fsm: three instances (3x32, 1x32, 5x16), each served by a
// behavioural isqrt responder with adjustable latency.
module tb_nested_isqrt_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic longint unsigned isqrt_ref(input longint unsigned x);
    longint unsigned r = 0;
    for (int b = 31; b >= 0; b--) begin
      longint unsigned t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic longint unsigned chain_ref(input longint unsigned a[8], input int n, input int w);
    longint unsigned acc  = 0;
    longint unsigned mask = (64'd1 << w) - 1;
    for (int i = n - 1; i >= 0; i--) acc = isqrt_ref((a[i] + acc) & mask);
    return acc;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instance A: N_ARGS=3, W=32 ----------------
  logic        arg_vld_a = 1'b0, arg_rdy_a, res_vld_a, x_vld_a, y_vld_a;
  logic [95:0] args_a = '0;
  logic [31:0] res_a, x_a;
  logic [15:0] y_a;
  int          lat_a = 1, cnt_a = 0;
  logic        m_vld_a = 1'b0;
  logic [15:0] m_y_a = '0;
  logic        stray_vld = 1'b0;
  logic [15:0] stray_y = '0;

  assign y_vld_a = m_vld_a | stray_vld;
  assign y_a     = stray_vld ? stray_y : m_y_a;

  nested_isqrt_fsm #(.N_ARGS(3), .W(32)) dut_a (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_a), .arg_rdy(arg_rdy_a), .args(args_a),
    .res_vld(res_vld_a), .res(res_a), .isqrt_x_vld(x_vld_a), .isqrt_x(x_a),
    .isqrt_y_vld(y_vld_a), .isqrt_y(y_a));

  // The responder deliberately ignores rst so a result can arrive after a reset.
  always @(posedge clk) begin
    m_vld_a <= 1'b0;
    if (x_vld_a) begin
      m_y_a <= 16'(isqrt_ref(64'(x_a)));
      if (lat_a <= 1) m_vld_a <= 1'b1;
      else cnt_a <= lat_a - 1;
    end else if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) m_vld_a <= 1'b1;
    end
  end

  // ---------------- instance B: N_ARGS=1, W=32 ----------------
  logic        arg_vld_b = 1'b0, arg_rdy_b, res_vld_b, x_vld_b;
  logic [31:0] args_b = '0, res_b, x_b;
  int          lat_b = 1, cnt_b = 0;
  logic        m_vld_b = 1'b0;
  logic [15:0] m_y_b = '0;

  nested_isqrt_fsm #(.N_ARGS(1), .W(32)) dut_b (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_b), .arg_rdy(arg_rdy_b), .args(args_b),
    .res_vld(res_vld_b), .res(res_b), .isqrt_x_vld(x_vld_b), .isqrt_x(x_b),
    .isqrt_y_vld(m_vld_b), .isqrt_y(m_y_b));

  always @(posedge clk) begin
    m_vld_b <= 1'b0;
    if (x_vld_b) begin
      m_y_b <= 16'(isqrt_ref(64'(x_b)));
      if (lat_b <= 1) m_vld_b <= 1'b1;
      else cnt_b <= lat_b - 1;
    end else if (cnt_b > 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) m_vld_b <= 1'b1;
    end
  end

  // ---------------- instance C: N_ARGS=5, W=16 ----------------
  logic        arg_vld_c = 1'b0, arg_rdy_c, res_vld_c, x_vld_c;
  logic [79:0] args_c = '0;
  logic [15:0] res_c, x_c;
  int          lat_c = 1, cnt_c = 0;
  logic        m_vld_c = 1'b0;
  logic [7:0]  m_y_c = '0;

  nested_isqrt_fsm #(.N_ARGS(5), .W(16)) dut_c (
    .clk(clk), .rst(rst), .arg_vld(arg_vld_c), .arg_rdy(arg_rdy_c), .args(args_c),
    .res_vld(res_vld_c), .res(res_c), .isqrt_x_vld(x_vld_c), .isqrt_x(x_c),
    .isqrt_y_vld(m_vld_c), .isqrt_y(m_y_c));

  always @(posedge clk) begin
    m_vld_c <= 1'b0;
    if (x_vld_c) begin
      m_y_c <= 8'(isqrt_ref(64'(x_c)));
      if (lat_c <= 1) m_vld_c <= 1'b1;
      else cnt_c <= lat_c - 1;
    end else if (cnt_c > 0) begin
      cnt_c <= cnt_c - 1;
      if (cnt_c == 1) m_vld_c <= 1'b1;
    end
  end

  // ---------------- drivers ----------------
  task automatic run_a(input logic [95:0] a, input int lat, output logic [2:0][31:0] xs,
                       output int nx, output int done_cyc, output logic [31:0] r, output int busy_rdy);
    lat_a = lat; nx = 0; done_cyc = -1; busy_rdy = 0; xs = '0; r = '0;
    @(negedge clk); args_a = a; arg_vld_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
      @(negedge clk); arg_vld_a = 1'b0;
      if (x_vld_a) begin
        if (nx < 3) xs[nx] = x_a;
        nx++;
      end
      if (res_vld_a) begin done_cyc = c; r = res_a; end
      else if (arg_rdy_a) busy_rdy++;
    end
  endtask

  task automatic run_b(input logic [31:0] a, output logic [31:0] r, output int cyc);
    r = '0; cyc = -1;
    @(negedge clk); args_b = a; arg_vld_b = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100 && cyc < 0; c++) begin
      @(negedge clk); arg_vld_b = 1'b0;
      if (res_vld_b) begin cyc = c; r = res_b; end
    end
  endtask

  task automatic run_c(input logic [79:0] a, input int lat, output logic [15:0] r, output int cyc);
    lat_c = lat; r = '0; cyc = -1;
    @(negedge clk); args_c = a; arg_vld_c = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 300 && cyc < 0; c++) begin
      @(negedge clk); arg_vld_c = 1'b0;
      if (res_vld_c) begin cyc = c; r = res_c; end
    end
  endtask

  typedef struct {
    logic [31:0] a0, a1, a2;
    logic [31:0] x0, x1, x2;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] r;
  } vec1_t;

  initial begin
    vec_t            vecs[5];
    vec1_t           vb[5];
    logic [2:0][31:0] xs;
    logic [31:0]     r, r1, r2;
    logic [15:0]     rc;
    int              nx, dc, br, first, second, bad;
    longint unsigned ac[8];
    logic [79:0]     pc;

    vecs[0] = '{a0: 32'd5, a1: 32'd12, a2: 32'd16, x0: 32'd16, x1: 32'd16, x2: 32'd9, r: 32'd3};
    vecs[1] = '{a0: 32'd4, a1: 32'hFFFF_FFFF, a2: 32'd1, x0: 32'd1, x1: 32'd0, x2: 32'd4, r: 32'd2};
    vecs[2] = '{a0: 32'd0, a1: 32'd0, a2: 32'd0, x0: 32'd0, x1: 32'd0, x2: 32'd0, r: 32'd0};
    vecs[3] = '{a0: 32'd49, a1: 32'd0, a2: 32'd0, x0: 32'd0, x1: 32'd0, x2: 32'd49, r: 32'd7};
    vecs[4] = '{a0: 32'd0, a1: 32'd0, a2: 32'hFFFF_FFFF, x0: 32'hFFFF_FFFF, x1: 32'd65535, x2: 32'd255, r: 32'd15};
    vb[0] = '{a: 32'hFFFF_FFFF, r: 32'd65535};
    vb[1] = '{a: 32'h0, r: 32'd0};
    vb[2] = '{a: 32'hFFFE_0001, r: 32'd65535};
    vb[3] = '{a: 32'hFFFE_0000, r: 32'd65534};
    vb[4] = '{a: 32'd1, r: 32'd1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset arg_rdy", 64'(arg_rdy_a), 64'd1);
    check("reset res_vld", 64'(res_vld_a), 64'd0);
    check("reset res", 64'(res_a), 64'd0);
    check("reset x_vld", 64'(x_vld_a), 64'd0);
    check("reset x", 64'(x_a), 64'd0);
    rst = 1'b0;

    // Reset while waiting on the second request, then a late result and a stray strobe in IDLE
    lat_a = 3;
    @(negedge clk); args_a = {32'd16, 32'd12, 32'd5}; arg_vld_a = 1'b1;
    @(posedge clk);
    @(negedge clk); arg_vld_a = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst arg_rdy", 64'(arg_rdy_a), 64'd1);
    check("midrst x_vld", 64'(x_vld_a), 64'd0);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 4) begin stray_vld = 1'b1; stray_y = 16'd9; end
      else stray_vld = 1'b0;
      if (res_vld_a || x_vld_a || !arg_rdy_a || (res_a != 32'd0)) bad++;
      @(negedge clk);
    end
    stray_vld = 1'b0;
    check("midrst/stray disturbances", 64'(bad), 64'd0);
    check("midrst res held 0", 64'(res_a), 64'd0);
    run_a({32'd16, 32'd12, 32'd5}, 1, xs, nx, dc, r, br);
    check("post-reset res", 64'(r), 64'd3);

    // Table of single transactions, L=1
    for (int i = 0; i < 5; i++) begin
      run_a({vecs[i].a2, vecs[i].a1, vecs[i].a0}, 1, xs, nx, dc, r, br);
      check($sformatf("vec%0d req count", i), 64'(nx), 64'd3);
      check($sformatf("vec%0d x0", i), 64'(xs[0]), 64'(vecs[i].x0));
      check($sformatf("vec%0d x1", i), 64'(xs[1]), 64'(vecs[i].x1));
      check($sformatf("vec%0d x2", i), 64'(xs[2]), 64'(vecs[i].x2));
      check($sformatf("vec%0d res", i), 64'(r), 64'(vecs[i].r));
      check($sformatf("vec%0d res_vld cycle", i), 64'(dc), 64'd7);
      check($sformatf("vec%0d busy arg_rdy", i), 64'(br), 64'd0);
    end

    // Longer latency timing, then result hold
    run_a({32'd16, 32'd12, 32'd5}, 3, xs, nx, dc, r, br);
    check("L3 res", 64'(r), 64'd3);
    check("L3 res_vld cycle", 64'(dc), 64'd13);
    repeat (4) @(negedge clk);
    check("res hold value", 64'(res_a), 64'd3);
    check("res_vld single pulse", 64'(res_vld_a), 64'd0);

    // Back-to-back with arg_vld held high
    lat_a = 1; first = -1; second = -1; bad = 0; r1 = '0; r2 = '0;
    @(negedge clk); args_a = {32'd16, 32'd12, 32'd5}; arg_vld_a = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60 && second < 0; c++) begin
      @(negedge clk);
      if (c == 1) args_a = {32'd0, 32'd0, 32'd49};
      if (res_vld_a) begin
        if (first < 0) begin
          first = c; r1 = res_a;
          if (!arg_rdy_a) bad++;
        end else begin
          second = c; r2 = res_a;
        end
      end else if (arg_rdy_a) bad++;
      if (first > 0 && c == first + 1) arg_vld_a = 1'b0;
    end
    arg_vld_a = 1'b0;
    check("b2b res1", 64'(r1), 64'd3);
    check("b2b res2", 64'(r2), 64'd7);
    check("b2b first cycle", 64'(first), 64'd7);
    check("b2b second cycle", 64'(second), 64'd14);
    check("b2b arg_rdy while busy", 64'(bad), 64'd0);

    // Single-argument chain
    for (int i = 0; i < 5; i++) begin
      run_b(vb[i].a, r, dc);
      check($sformatf("n1 vec%0d res", i), 64'(r), 64'(vb[i].r));
      check($sformatf("n1 vec%0d cycle", i), 64'(dc), 64'd3);
    end

    // Random sets against the chain model, random latency
    for (int k = 0; k < 1000; k++) begin
      int lat;
      lat = int'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++) ac[i] = 0;
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 3) == 0) ac[i] = longint'($urandom_range(0, 40));
        else ac[i] = longint'($urandom & 32'hFFFF);
        pc[16*i +: 16] = ac[i][15:0];
      end
      run_c(pc, lat, rc, dc);
      check($sformatf("rand%0d res", k), 64'(rc), 64'(chain_ref(ac, 5, 16)));
      check($sformatf("rand%0d cycle L=%0d", k, lat), 64'(dc), 64'(5 * (lat + 1) + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 5000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
